// File: rtl/control_verificador_pkg.sv
// Shared state encoding and counter-width helper for the adder checker and its bench monitors.
// Combinational helper only; no latency or flow control of its own.
package control_verificador_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Counters must hold NUM_CHECKS itself (all samples mismatching).
   function automatic int calc_cnt_w(input int num_checks);
      return $clog2(num_checks + 1);
   endfunction

endpackage

// File: rtl/control_verificador_if.sv
// Bundle of stimulus/result signals between the bench top and the checker.
// FIRST_ERR_CAPTURE_EN adds first_err_val1/first_err_val2.
interface control_verificador_if #(
   parameter int BITS  = 2,
   parameter int CNT_W = 5
);
   logic             start;
   logic [BITS-1:0]  signal1;
   logic [BITS-1:0]  signal2;
   logic             busy;
   logic             done;
   logic             pass;
   logic [CNT_W-1:0] err_count;
   logic [CNT_W-1:0] first_err_idx;
`ifdef FIRST_ERR_CAPTURE_EN
   logic [BITS-1:0]  first_err_val1;
   logic [BITS-1:0]  first_err_val2;
`endif

   modport master (
      output start, signal1, signal2,
`ifdef FIRST_ERR_CAPTURE_EN
      input  first_err_val1, first_err_val2,
`endif
      input  busy, done, pass, err_count, first_err_idx
   );

   modport slave (
      input  start, signal1, signal2,
`ifdef FIRST_ERR_CAPTURE_EN
      output first_err_val1, first_err_val2,
`endif
      output busy, done, pass, err_count, first_err_idx
   );
endinterface

// File: rtl/control_verificador_comparador_4est.sv
// Four-state equality of two vectors: X/Z only match when bit-identical.
// Purely combinational, no backpressure.
module comparador_4est #(
   parameter int BITS = 2
) (
   input  logic [BITS-1:0] a,
   input  logic [BITS-1:0] b,
   output logic            match
);
   assign match = (a === b);
endmodule

// File: rtl/control_verificador.sv
// Checker sequencer: skips LATENCY fill cycles, compares NUM_CHECKS samples, reports done/pass.
// Done rises LATENCY+NUM_CHECKS edges after start; start ignored while busy. Option: FIRST_ERR_CAPTURE_EN.
module control_verificador
   import control_verificador_pkg::*;
#(
   parameter int  BITS       = 2,
   parameter int  LATENCY    = 4,
   parameter int  NUM_CHECKS = 16,
   localparam int CNT_W      = calc_cnt_w(NUM_CHECKS)
) (
   input logic                  clk,
   input logic                  reset_L,
   control_verificador_if.slave vif
);
   localparam int FILL_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   state_t            state_q, state_d;
   logic [FILL_W-1:0] fill_cnt_q, fill_cnt_d;
   logic [CNT_W-1:0]  chk_idx_q, chk_idx_d;
   logic [CNT_W-1:0]  err_count_q, err_count_d;
   logic [CNT_W-1:0]  first_err_idx_q, first_err_idx_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              pass_q, pass_d;
`ifdef FIRST_ERR_CAPTURE_EN
   logic [BITS-1:0]   val1_q, val1_d;
   logic [BITS-1:0]   val2_q, val2_d;
`endif
   logic              match;

   comparador_4est #(.BITS(BITS)) u_cmp (
      .a     (vif.signal1),
      .b     (vif.signal2),
      .match (match)
   );

   always_comb begin
      state_d         = state_q;
      fill_cnt_d      = fill_cnt_q;
      chk_idx_d       = chk_idx_q;
      err_count_d     = err_count_q;
      first_err_idx_d = first_err_idx_q;
      busy_d          = busy_q;
      done_d          = done_q;
      pass_d          = pass_q;
`ifdef FIRST_ERR_CAPTURE_EN
      val1_d          = val1_q;
      val2_d          = val2_q;
`endif
      case (state_q)
         IDLE, DONE: begin
            if (vif.start) begin
               state_d         = (LATENCY == 0) ? CHECK : FILL;
               fill_cnt_d      = '0;
               chk_idx_d       = '0;
               err_count_d     = '0;
               first_err_idx_d = '0;
               busy_d          = 1'b1;
               done_d          = 1'b0;
               pass_d          = 1'b0;
`ifdef FIRST_ERR_CAPTURE_EN
               val1_d          = '0;
               val2_d          = '0;
`endif
            end
         end
         FILL: begin
            fill_cnt_d = fill_cnt_q + FILL_W'(1);
            if (int'(fill_cnt_q) == LATENCY - 1) begin
               state_d    = CHECK;
               fill_cnt_d = '0;
            end
         end
         CHECK: begin
            if (!match) begin
               err_count_d = err_count_q + CNT_W'(1);
               if (err_count_q == '0) begin
                  first_err_idx_d = chk_idx_q;
`ifdef FIRST_ERR_CAPTURE_EN
                  val1_d          = vif.signal1;
                  val2_d          = vif.signal2;
`endif
               end
            end
            chk_idx_d = chk_idx_q + CNT_W'(1);
            // Verdict is taken from the count including this last sample.
            if (int'(chk_idx_q) == NUM_CHECKS - 1) begin
               state_d = DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = (err_count_d == '0);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_L) begin
         state_q         <= IDLE;
         fill_cnt_q      <= '0;
         chk_idx_q       <= '0;
         err_count_q     <= '0;
         first_err_idx_q <= '0;
         busy_q          <= 1'b0;
         done_q          <= 1'b0;
         pass_q          <= 1'b0;
`ifdef FIRST_ERR_CAPTURE_EN
         val1_q          <= '0;
         val2_q          <= '0;
`endif
      end else begin
         state_q         <= state_d;
         fill_cnt_q      <= fill_cnt_d;
         chk_idx_q       <= chk_idx_d;
         err_count_q     <= err_count_d;
         first_err_idx_q <= first_err_idx_d;
         busy_q          <= busy_d;
         done_q          <= done_d;
         pass_q          <= pass_d;
`ifdef FIRST_ERR_CAPTURE_EN
         val1_q          <= val1_d;
         val2_q          <= val2_d;
`endif
      end
   end

   assign vif.busy          = busy_q;
   assign vif.done          = done_q;
   assign vif.pass          = pass_q;
   assign vif.err_count     = err_count_q;
   assign vif.first_err_idx = first_err_idx_q;
`ifdef FIRST_ERR_CAPTURE_EN
   assign vif.first_err_val1 = val1_q;
   assign vif.first_err_val2 = val2_q;
`endif

endmodule

// File: tb/tb_control_verificador.sv
// Bench for control_verificador (BITS=2, LATENCY=3, NUM_CHECKS=8); honours FIRST_ERR_CAPTURE_EN.
module tb_control_verificador;
   localparam int BITS  = 2;
   localparam int LAT   = 3;
   localparam int NCH   = 8;
   localparam int CNT_W = 4;

   typedef struct packed {
      logic [CNT_W-1:0] err;
      logic [CNT_W-1:0] idx;
      logic             pass;
      logic [BITS-1:0]  v1;
      logic [BITS-1:0]  v2;
   } exp_t;

   typedef struct {
      logic [2*NCH-1:0] s1;
      logic [2*NCH-1:0] s2;
      bit               garbage;
      bit               hold;
      exp_t             exp;
   } vec_t;

   logic clk = 1'b0;
   logic reset_L;
   int   tests = 0;
   int   fails = 0;
   exp_t sb_q[$];
   vec_t tbl[6];

   control_verificador_if #(.BITS(BITS), .CNT_W(CNT_W)) vif();

   control_verificador #(.BITS(BITS), .LATENCY(LAT), .NUM_CHECKS(NCH)) dut (
      .clk     (clk),
      .reset_L (reset_L),
      .vif     (vif)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic exp_t model(input logic [2*NCH-1:0] s1, input logic [2*NCH-1:0] s2);
      exp_t e;
      e = '0;
      for (int k = 0; k < NCH; k++) begin
         if (s1[2*k +: 2] !== s2[2*k +: 2]) begin
            if (e.err == '0) begin
               e.idx = CNT_W'(k);
               e.v1  = s1[2*k +: 2];
               e.v2  = s2[2*k +: 2];
            end
            e.err = e.err + CNT_W'(1);
         end
      end
      e.pass = (e.err == '0);
      return e;
   endfunction

   task automatic do_run(input string tag, input logic [2*NCH-1:0] s1, input logic [2*NCH-1:0] s2,
                         input bit garbage, input bit hold, input exp_t exp);
      int   cyc;
      int   busy_cnt;
      bit   got;
      exp_t e;
      sb_q.push_back(exp);
      @(negedge clk);
      vif.start = 1'b1; vif.signal1 = '0; vif.signal2 = '0;
      @(posedge clk);
      cyc = 0; busy_cnt = 0; got = 1'b0;
      while (cyc < 40) begin
         @(negedge clk);
         if (vif.done) begin got = 1'b1; break; end
         if (vif.busy) busy_cnt++;
         if (cyc == 0) chk({tag, "_cleared_on_start"}, 32'(vif.err_count), 32'd0);
         vif.start = hold;
         cyc++;
         if (cyc <= LAT) begin
            vif.signal1 = garbage ? 2'b11 : 2'b00;
            vif.signal2 = garbage ? 2'b01 : 2'b00;
         end else if (cyc <= LAT + NCH) begin
            vif.signal1 = s1[2*(cyc-LAT-1) +: 2];
            vif.signal2 = s2[2*(cyc-LAT-1) +: 2];
         end else begin
            vif.signal1 = '0; vif.signal2 = '0;
         end
         @(posedge clk);
      end
      vif.start = 1'b0;
      chk({tag, "_done_seen"}, 32'(got), 32'd1);
      chk({tag, "_run_len"}, 32'(cyc), 32'(LAT + NCH));
      chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(LAT + NCH));
      chk({tag, "_busy_low_in_done"}, 32'(vif.busy), 32'd0);
      if (sb_q.size() == 0) begin
         chk({tag, "_scoreboard_nonempty"}, 32'(sb_q.size()), 32'd1);
      end else begin
         e = sb_q.pop_front();
         chk({tag, "_err_count"}, 32'(vif.err_count), 32'(e.err));
         chk({tag, "_first_err_idx"}, 32'(vif.first_err_idx), 32'(e.idx));
         chk({tag, "_pass"}, 32'(vif.pass), 32'(e.pass));
`ifdef FIRST_ERR_CAPTURE_EN
         chk({tag, "_val1"}, 32'(vif.first_err_val1), 32'(e.v1));
         chk({tag, "_val2"}, 32'(vif.first_err_val2), 32'(e.v2));
`endif
      end
      // Results must hold while idling in DONE.
      repeat (3) @(negedge clk);
      chk({tag, "_done_held"}, 32'(vif.done), 32'd1);
   endtask

   initial begin
      logic [2*NCH-1:0] xs;
      logic [2*NCH-1:0] s0x;

      // Streams packed with sample k in bits [2k+1:2k]; base is 0,1,2,3,0,1,2,3.
      tbl[0] = '{16'hE4E4, 16'hE4E4, 1'b0, 1'b0, '{err:4'd0, idx:4'd0, pass:1'b1, v1:2'd0, v2:2'd0}};
      tbl[1] = '{16'hE0D4, 16'hE4E4, 1'b0, 1'b0, '{err:4'd2, idx:4'd2, pass:1'b0, v1:2'd1, v2:2'd2}};
      tbl[2] = '{16'hE4E4, 16'hE4E4, 1'b1, 1'b0, '{err:4'd0, idx:4'd0, pass:1'b1, v1:2'd0, v2:2'd0}};
      tbl[3] = '{16'hE4E4, 16'hE4E4, 1'b0, 1'b1, '{err:4'd0, idx:4'd0, pass:1'b1, v1:2'd0, v2:2'd0}};
      tbl[4] = '{16'h0000, 16'hFFFF, 1'b0, 1'b0, '{err:4'd8, idx:4'd0, pass:1'b0, v1:2'd0, v2:2'd3}};
      tbl[5] = '{16'h24E4, 16'hE4E4, 1'b0, 1'b0, '{err:4'd1, idx:4'd7, pass:1'b0, v1:2'd0, v2:2'd3}};

      reset_L = 1'b0; vif.start = 1'b0; vif.signal1 = '0; vif.signal2 = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", 32'(vif.busy), 32'd0);
      chk("rst_done", 32'(vif.done), 32'd0);
      chk("rst_pass", 32'(vif.pass), 32'd0);
      chk("rst_err", 32'(vif.err_count), 32'd0);
      chk("rst_idx", 32'(vif.first_err_idx), 32'd0);
      reset_L = 1'b1;

      for (int i = 0; i < 6; i++)
         do_run($sformatf("vec%0d", i), tbl[i].s1, tbl[i].s2, tbl[i].garbage, tbl[i].hold, tbl[i].exp);

      // Four-state cases: expectations come from the bench's own === model of the driven values.
      xs = 'x;
      do_run("both_x", xs, xs, 1'b0, 1'b0, model(xs, xs));
      s0x = 16'hE4E4;
      s0x[1:0] = 2'b0x;
      do_run("zero_x_vs_zero", s0x, 16'hE4E4, 1'b0, 1'b0, model(s0x, 16'hE4E4));

      // Reset mid-CHECK after one logged error, then a clean run.
      @(negedge clk);
      vif.start = 1'b1; vif.signal1 = '0; vif.signal2 = '0;
      @(posedge clk);
      for (int c = 1; c <= LAT + 2; c++) begin
         @(negedge clk);
         vif.start = 1'b0;
         vif.signal1 = (c == LAT + 1) ? 2'b01 : 2'b00;
         vif.signal2 = 2'b00;
         @(posedge clk);
      end
      @(negedge clk);
      chk("midrun_err_logged", 32'(vif.err_count), 32'd1);
      chk("midrun_busy", 32'(vif.busy), 32'd1);
      reset_L = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset_L = 1'b1;
      chk("abort_busy", 32'(vif.busy), 32'd0);
      chk("abort_done", 32'(vif.done), 32'd0);
      chk("abort_pass", 32'(vif.pass), 32'd0);
      chk("abort_err", 32'(vif.err_count), 32'd0);
      chk("abort_idx", 32'(vif.first_err_idx), 32'd0);
`ifdef FIRST_ERR_CAPTURE_EN
      chk("abort_val1", 32'(vif.first_err_val1), 32'd0);
      chk("abort_val2", 32'(vif.first_err_val2), 32'd0);
`endif
      do_run("after_abort", tbl[0].s1, tbl[0].s2, 1'b0, 1'b0, tbl[0].exp);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got stuck expected finish");
      $fatal(1);
   end
endmodule

// File: doc/control_verificador.md
Name: control_verificador

Overview:
- Sequencer/scoreboard controller for checking the pipelined adder against its behavioural model.
- On `start`, waits out the pipeline fill latency, then compares the two result streams for a fixed number of cycles. Mismatches are counted and the first failing sample index is recorded.
- Ends with `done` and a `pass` verdict. Sits in the testbench layer, between the two adder instances and the bench top.

Parameters:
- BITS, 2, width of compared signals
- LATENCY, 4, pipeline fill cycles to skip after start (0 allowed)
- NUM_CHECKS, 16, number of consecutive cycles compared (>=1)
- CNT_W, $clog2(NUM_CHECKS+1), width of counters/index outputs (derived, not overridden)

Ports:
- clk  in  1  clock; all logic on posedge
- reset_L  in  1  synchronous reset, active-low
- start  in  1  begin a check run (pulse or level; sampled only in IDLE/DONE)
- signal1  in  BITS  DUT (pipelined) result
- signal2  in  BITS  reference (behavioural) result
- busy  out  1  high in FILL and CHECK
- done  out  1  high in DONE
- pass  out  1  valid when done; 1 iff err_count==0
- err_count  out  CNT_W  mismatches in current/last run
- first_err_idx  out  CNT_W  CHECK-cycle index (0-based) of first mismatch; valid when err_count!=0

Behaviour:
- Reset (reset_L==0 at posedge):
  - state=IDLE.
  - busy, done, pass, err_count, first_err_idx, fill counter, check index all 0.
  - Reset mid-run aborts with no residue.
- States:
  - IDLE: outputs idle. start=1 -> FILL, or -> CHECK if LATENCY==0. On entry to FILL/CHECK: err_count, first_err_idx, counters cleared.
  - FILL: fill counter counts 0..LATENCY-1, one per cycle. No comparison. Leaves for CHECK on the edge where the counter==LATENCY-1, i.e. exactly LATENCY cycles in FILL.
  - CHECK: every cycle, compare signal1 vs signal2 with 4-state case equality. X/Z match only if bit-identical (xx==xx passes, 0x vs 00 fails).
    - On mismatch: err_count increments at the next edge.
    - If err_count==0 before the increment, first_err_idx<=check index.
    - Check index increments each cycle. After the compare at index NUM_CHECKS-1 -> DONE.
  - DONE: done=1; pass=(err_count==0), registered on DONE entry. Results held stable indefinitely. start=1 -> same as from IDLE (clear, restart).
- start is ignored in FILL and CHECK (no restart, no extension).
- Latency: done/pass rise 1 cycle after the last compared sample. Total run = LATENCY + NUM_CHECKS cycles from the start-sampling edge to the done-rising edge.
- err_count cannot overflow: max value NUM_CHECKS fits CNT_W. No saturation logic needed.
- All outputs are registered; no combinational input-to-output paths.

Optional Feature:
- FIRST_ERR_CAPTURE_EN: adds outputs `first_err_val1` and `first_err_val2` (BITS each). They capture signal1/signal2 at the first mismatch, are cleared to 0 at reset and run start, and hold through DONE.
- Without the macro: ports and registers absent; everything else identical.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, FILL=2'd1, CHECK=2'd2, DONE=2'd3) and the CNT_W derivation function, for reuse by the bench monitors.
- One natural sub-module: `comparador_4est`, a combinational 4-state equality of two BITS-wide vectors producing `match`. The controller owns all registers.

Test Plan (BITS=2, LATENCY=3, NUM_CHECKS=8):
- Identical streams 0,1,2,3,0,1,2,3, start pulse -> busy for 11 cycles; done=1 and pass=1 on the 12th edge; err_count=0.
- signal1 differs at CHECK indices 2 and 5 -> err_count=2, first_err_idx=2, pass=0; with FIRST_ERR_CAPTURE_EN, val1/val2 equal the index-2 values.
- Both signals 2'bxx throughout CHECK -> pass=1. signal1=2'b0x vs signal2=2'b00 at index 0 -> err_count=1, first_err_idx=0.
- Garbage mismatches during FILL only, then matching data -> pass=1 (fill cycles not compared).
- start held high during CHECK -> no restart, done on schedule. start in DONE -> counters cleared, new run, previous results overwritten.
- reset_L=0 mid-CHECK with 1 error logged -> next cycle all outputs 0, state IDLE. A fresh start then yields a clean run.
